// File: rtl/dict_pkg.sv
// Shared definitions for the dictionary boot loader and the compression controller:
// field widths, image header layout, FSM state codes and dictionary selection helper.
package dict_pkg;

    localparam int unsigned DICT1_KEY_W = 3;
    localparam int unsigned DICT2_KEY_W = 5;
    localparam int unsigned DICT3_KEY_W = 8;
    localparam int unsigned DICT1_VAL_W = 7;
    localparam int unsigned DICT2_VAL_W = 10;
    localparam int unsigned DICT3_VAL_W = 15;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 9;

    localparam logic [31:0] DICT_BASE_ADDR_DEF = 32'h0000_F000;
    localparam logic [11:0] DICT_MAGIC         = 12'hD1C;

    localparam int unsigned MAGIC_LSB = 20;
    localparam int unsigned MAGIC_MSB = 31;
    localparam int unsigned RSVD_BIT  = 19;
    localparam int unsigned N3_LSB    = 10;
    localparam int unsigned N3_MSB    = 18;
    localparam int unsigned N2_LSB    = 4;
    localparam int unsigned N2_MSB    = 9;
    localparam int unsigned N1_LSB    = 0;
    localparam int unsigned N1_MSB    = 3;

    // Image header word as read from memory
    typedef struct packed {
        logic [MAGIC_MSB-MAGIC_LSB:0] magic;
        logic                         rsvd;
        logic [N3_MSB-N3_LSB:0]       n3;
        logic [N2_MSB-N2_LSB:0]       n2;
        logic [N1_MSB-N1_LSB:0]       n1;
    } dict_hdr_t;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR_REQ = 3'd1;
    localparam logic [2:0] S_HDR_CHK = 3'd2;
    localparam logic [2:0] S_ENT_REQ = 3'd3;
    localparam logic [2:0] S_ENT_WR  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_D1   = 2'd1;
    localparam logic [1:0] SEL_D2   = 2'd2;
    localparam logic [1:0] SEL_D3   = 2'd3;

    // First dictionary after cur with a nonzero entry count, SEL_NONE if none left
    function automatic logic [1:0] next_dict(
        input logic [1:0]             cur,
        input logic [N1_MSB-N1_LSB:0] n1,
        input logic [N2_MSB-N2_LSB:0] n2,
        input logic [N3_MSB-N3_LSB:0] n3
    );
        next_dict = SEL_NONE;
        if (cur < SEL_D1 && n1 != '0) begin
            next_dict = SEL_D1;
        end else if (cur < SEL_D2 && n2 != '0) begin
            next_dict = SEL_D2;
        end else if (cur < SEL_D3 && n3 != '0) begin
            next_dict = SEL_D3;
        end
    endfunction

endpackage

// File: rtl/dict_loader.sv
// Boot-time loader: reads the dictionary image from instruction memory and
// replays it into the dict1/dict2/dict3 write ports in key order.
module dict_loader
    import dict_pkg::*;
#(
    parameter int unsigned FIELD1_KEY_WIDTH = DICT1_KEY_W,
    parameter int unsigned FIELD2_KEY_WIDTH = DICT2_KEY_W,
    parameter int unsigned FIELD3_KEY_WIDTH = DICT3_KEY_W,
    parameter int unsigned FIELD1_VAL_WIDTH = DICT1_VAL_W,
    parameter int unsigned FIELD2_VAL_WIDTH = DICT2_VAL_W,
    parameter int unsigned FIELD3_VAL_WIDTH = DICT3_VAL_W,
    parameter logic [31:0] DICT_BASE_ADDR   = DICT_BASE_ADDR_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        dict_ready,
    output logic                        load_error,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [ADDR_W-1:0]           mem_req_addr,
    input  logic [DATA_W-1:0]           mem_req_rdata,
    output logic                        dict1_write_enable,
    output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
    output logic                        dict2_write_enable,
    output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
    output logic                        dict3_write_enable,
    output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val
);

    localparam logic [CNT_W-1:0] CAP1 = CNT_W'(1 << FIELD1_KEY_WIDTH);
    localparam logic [CNT_W-1:0] CAP2 = CNT_W'(1 << FIELD2_KEY_WIDTH);
    localparam logic [CNT_W-1:0] CAP3 = CNT_W'(1 << FIELD3_KEY_WIDTH);

    logic [2:0]       state_q, state_nxt;
    dict_hdr_t        hdr_q, hdr_nxt;
    logic [1:0]       sel_q, sel_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    logic                        busy_nxt, ready_nxt, err_nxt, valid_nxt;
    logic [ADDR_W-1:0]           addr_nxt;
    logic                        we1_nxt, we2_nxt, we3_nxt;
    logic [FIELD1_VAL_WIDTH-1:0] val1_nxt;
    logic [FIELD2_VAL_WIDTH-1:0] val2_nxt;
    logic [FIELD3_VAL_WIDTH-1:0] val3_nxt;

    logic [CNT_W-1:0] cnt_inc, cur_total;
    logic [1:0]       sel_first, sel_after;
    logic             hdr_bad;

    // The reserved header bit carries no meaning
    logic unused_hdr_rsvd;
    assign unused_hdr_rsvd = hdr_q.rsvd;

    // Next-state and registered-output logic
    always_comb begin
        state_nxt = state_q;
        hdr_nxt   = hdr_q;
        sel_nxt   = sel_q;
        cnt_nxt   = cnt_q;
        busy_nxt  = busy;
        ready_nxt = dict_ready;
        err_nxt   = load_error;
        valid_nxt = mem_req_valid;
        addr_nxt  = mem_req_addr;
        we1_nxt   = 1'b0;
        we2_nxt   = 1'b0;
        we3_nxt   = 1'b0;
        val1_nxt  = '0;
        val2_nxt  = '0;
        val3_nxt  = '0;

        cnt_inc   = cnt_q + CNT_W'(1);
        sel_first = next_dict(SEL_NONE, hdr_q.n1, hdr_q.n2, hdr_q.n3);
        sel_after = next_dict(sel_q, hdr_q.n1, hdr_q.n2, hdr_q.n3);
        hdr_bad   = (hdr_q.magic != DICT_MAGIC)
                  || (CNT_W'(hdr_q.n1) > CAP1)
                  || (CNT_W'(hdr_q.n2) > CAP2)
                  || (CNT_W'(hdr_q.n3) > CAP3);

        case (sel_q)
            SEL_D1:  cur_total = CNT_W'(hdr_q.n1);
            SEL_D2:  cur_total = CNT_W'(hdr_q.n2);
            SEL_D3:  cur_total = CNT_W'(hdr_q.n3);
            default: cur_total = '0;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_nxt  = 1'b1;
                    addr_nxt  = DICT_BASE_ADDR;
                    valid_nxt = 1'b1;
                    state_nxt = S_HDR_REQ;
                end
            end
            S_HDR_REQ: begin
                if (mem_req_valid && mem_req_ready) begin
                    hdr_nxt   = dict_hdr_t'(mem_req_rdata);
                    valid_nxt = 1'b0;
                    state_nxt = S_HDR_CHK;
                end
            end
            S_HDR_CHK: begin
                if (hdr_bad) begin
                    busy_nxt  = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = S_ERROR;
                end else if (sel_first == SEL_NONE) begin
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    sel_nxt   = sel_first;
                    cnt_nxt   = '0;
                    addr_nxt  = mem_req_addr + ADDR_W'(4);
                    state_nxt = S_ENT_REQ;
                end
            end
            S_ENT_REQ: begin
                // First cycle here raises valid; the entry is captured on the ready cycle
                if (!mem_req_valid) begin
                    valid_nxt = 1'b1;
                end else if (mem_req_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = S_ENT_WR;
                    case (sel_q)
                        SEL_D1: begin
                            we1_nxt  = 1'b1;
                            val1_nxt = mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
                        end
                        SEL_D2: begin
                            we2_nxt  = 1'b1;
                            val2_nxt = mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
                        end
                        SEL_D3: begin
                            we3_nxt  = 1'b1;
                            val3_nxt = mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
                        end
                        default: ;
                    endcase
                end
            end
            S_ENT_WR: begin
                addr_nxt = mem_req_addr + ADDR_W'(4);
                if (cnt_inc == cur_total) begin
                    cnt_nxt = '0;
                    if (sel_after == SEL_NONE) begin
                        busy_nxt  = 1'b0;
                        ready_nxt = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        sel_nxt   = sel_after;
                        state_nxt = S_ENT_REQ;
                    end
                end else begin
                    cnt_nxt   = cnt_inc;
                    state_nxt = S_ENT_REQ;
                end
            end
            S_DONE, S_ERROR: ;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= S_IDLE;
            hdr_q              <= '0;
            sel_q              <= SEL_NONE;
            cnt_q              <= '0;
            busy               <= 1'b0;
            dict_ready         <= 1'b0;
            load_error         <= 1'b0;
            mem_req_valid      <= 1'b0;
            mem_req_addr       <= '0;
            dict1_write_enable <= 1'b0;
            dict1_write_val    <= '0;
            dict2_write_enable <= 1'b0;
            dict2_write_val    <= '0;
            dict3_write_enable <= 1'b0;
            dict3_write_val    <= '0;
        end else begin
            state_q            <= state_nxt;
            hdr_q              <= hdr_nxt;
            sel_q              <= sel_nxt;
            cnt_q              <= cnt_nxt;
            busy               <= busy_nxt;
            dict_ready         <= ready_nxt;
            load_error         <= err_nxt;
            mem_req_valid      <= valid_nxt;
            mem_req_addr       <= addr_nxt;
            dict1_write_enable <= we1_nxt;
            dict1_write_val    <= val1_nxt;
            dict2_write_enable <= we2_nxt;
            dict2_write_val    <= val2_nxt;
            dict3_write_enable <= we3_nxt;
            dict3_write_val    <= val3_nxt;
        end
    end

endmodule

// File: tb/tb_dict_loader.sv
// Directed bench for dict_loader: memory responder with programmable latency,
// write/request logging and per-scenario checks against hand-computed images.
module tb_dict_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        dict_ready;
    logic        load_error;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_rdata;
    logic        dict1_write_enable;
    logic [6:0]  dict1_write_val;
    logic        dict2_write_enable;
    logic [9:0]  dict2_write_val;
    logic        dict3_write_enable;
    logic [14:0] dict3_write_val;

    dict_loader dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .busy               (busy),
        .dict_ready         (dict_ready),
        .load_error         (load_error),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_addr       (mem_req_addr),
        .mem_req_rdata      (mem_req_rdata),
        .dict1_write_enable (dict1_write_enable),
        .dict1_write_val    (dict1_write_val),
        .dict2_write_enable (dict2_write_enable),
        .dict2_write_val    (dict2_write_val),
        .dict3_write_enable (dict3_write_enable),
        .dict3_write_val    (dict3_write_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] img [0:511];
    logic [6:0]  q1 [$];
    logic [9:0]  q2 [$];
    logic [14:0] q3 [$];
    logic [31:0] req_q [$];
    int          multi_we, val_err, stab_err;
    int          lat_fixed, cur_lat, wait_cnt;
    bit          lat_rand;
    bit          mon_prev_valid, mon_prev_reset;
    logic [31:0] mon_prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - 32'h0000_F000) >> 2;
        if (idx < 32'd512) return img[idx[8:0]];
        return 32'h0BAD_0BAD;
    endfunction

    // Monitor first (sees values from the last posedge), then memory responder
    initial begin
        mem_req_ready  = 1'b0;
        mem_req_rdata  = '0;
        wait_cnt       = 0;
        mon_prev_valid = 1'b0;
        mon_prev_reset = 1'b1;
        mon_prev_addr  = '0;
        forever begin
            @(negedge clk);
            if (dict1_write_enable) q1.push_back(dict1_write_val);
            if (dict2_write_enable) q2.push_back(dict2_write_val);
            if (dict3_write_enable) q3.push_back(dict3_write_val);
            if ((dict1_write_enable & dict2_write_enable) | (dict1_write_enable & dict3_write_enable)
                | (dict2_write_enable & dict3_write_enable)) multi_we++;
            if ((!dict1_write_enable && dict1_write_val != '0) || (!dict2_write_enable && dict2_write_val != '0)
                || (!dict3_write_enable && dict3_write_val != '0)) val_err++;
            if (mon_prev_valid && !mon_prev_reset) begin
                if (mem_req_ready) begin
                    if (mem_req_valid) stab_err++;
                end else if (!mem_req_valid || mem_req_addr != mon_prev_addr) begin
                    stab_err++;
                end
            end
            mon_prev_valid = mem_req_valid;
            mon_prev_addr  = mem_req_addr;
            mon_prev_reset = reset;

            if (mem_req_valid) begin
                if (wait_cnt >= cur_lat) begin
                    mem_req_ready = 1'b1;
                    mem_req_rdata = mem_word(mem_req_addr);
                    req_q.push_back(mem_req_addr);
                    wait_cnt = 0;
                    cur_lat  = lat_rand ? int'($urandom_range(0, 7)) : lat_fixed;
                end else begin
                    mem_req_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_req_ready = lat_rand ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_req_rdata = 32'hDEAD_BEEF;
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic clear_logs();
        q1.delete();
        q2.delete();
        q3.delete();
        req_q.delete();
        multi_we = 0;
        val_err  = 0;
        stab_err = 0;
        cur_lat  = lat_rand ? int'($urandom_range(0, 7)) : lat_fixed;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc++;
            if (dict_ready || load_error) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic load_mixed_image();
        img[0] = 32'hD1C0_0412;
        img[1] = 32'hFFFF_FF93;
        img[2] = 32'h0000_0033;
        img[3] = 32'hABCD_EEA5;
        img[4] = 32'h0000_FFFF;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (dict_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", dict_ready); end
        tests++; if (load_error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", load_error); end
        tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", mem_req_valid); end
        tests++; if (mem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", mem_req_addr); end
        tests++;
        if ({dict1_write_enable, dict2_write_enable, dict3_write_enable} !== 3'b000) begin
            fails++; $display("FAIL reset_we: got %b want 000", {dict1_write_enable, dict2_write_enable, dict3_write_enable});
        end
        tests++;
        if ({dict1_write_val, dict2_write_val, dict3_write_val} !== 32'h0) begin
            fails++; $display("FAIL reset_vals: got %h want 0", {dict1_write_val, dict2_write_val, dict3_write_val});
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_empty();
        int cyc;
        bit to;
        img[0] = 32'hD1C0_0000;
        lat_rand = 1'b0; lat_fixed = 2;
        do_reset(); clear_logs();
        pulse_start();
        wait_done(20, cyc, to);
        tests++; if (to) begin fails++; $display("FAIL empty_timeout: no completion in 20 cycles"); end
        tests++; if (cyc > 5) begin fails++; $display("FAIL empty_latency: got %0d cycles want <=5", cyc); end
        tests++; if (dict_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL empty_flags: got ready=%b busy=%b want 1 0", dict_ready, busy); end
        tests++; if (q1.size() + q2.size() + q3.size() != 0) begin
            fails++; $display("FAIL empty_writes: got %0d want 0", q1.size() + q2.size() + q3.size()); end
        tests++; if (req_q.size() != 1 || req_q[0] !== 32'h0000_F000) begin
            fails++; $display("FAIL empty_reads: got n=%0d first=%h want 1 F000", req_q.size(), req_q[0]); end
    endtask

    task automatic test_mixed();
        int cyc;
        bit to;
        int bad;
        load_mixed_image();
        lat_rand = 1'b0; lat_fixed = 1;
        do_reset(); clear_logs();
        pulse_start();
        wait_done(100, cyc, to);
        tests++; if (to || dict_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL mixed_done: got ready=%b busy=%b timeout=%b want 1 0 0", dict_ready, busy, to); end
        tests++; if (q1.size() != 2 || q1[0] !== 7'h13 || q1[1] !== 7'h33) begin
            fails++; $display("FAIL mixed_d1: got n=%0d %h %h want 2 13 33", q1.size(), q1[0], q1[1]); end
        tests++; if (q2.size() != 1 || q2[0] !== 10'h2A5) begin
            fails++; $display("FAIL mixed_d2: got n=%0d %h want 1 2a5", q2.size(), q2[0]); end
        tests++; if (q3.size() != 1 || q3[0] !== 15'h7FFF) begin
            fails++; $display("FAIL mixed_d3: got n=%0d %h want 1 7fff", q3.size(), q3[0]); end
        bad = 0;
        for (int i = 0; i < 5; i++) if (req_q[i] !== 32'h0000_F000 + 32'(4 * i)) bad++;
        tests++; if (req_q.size() != 5 || bad != 0) begin
            fails++; $display("FAIL mixed_addrs: got n=%0d wrong=%0d want 5 0", req_q.size(), bad); end
        tests++; if (multi_we + val_err + stab_err != 0) begin
            fails++; $display("FAIL mixed_protocol: got multi=%0d val=%0d stab=%0d want 0", multi_we, val_err, stab_err); end
    endtask

    task automatic test_bad_magic();
        int cyc;
        bit to;
        img[0] = 32'hABC0_0412;
        lat_rand = 1'b0; lat_fixed = 0;
        do_reset(); clear_logs();
        pulse_start();
        wait_done(20, cyc, to);
        tests++; if (to || load_error !== 1'b1 || dict_ready !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL magic_flags: got err=%b ready=%b busy=%b want 1 0 0", load_error, dict_ready, busy); end
        pulse_start();
        repeat (10) @(negedge clk);
        tests++; if (req_q.size() != 1 || busy !== 1'b0 || mem_req_valid !== 1'b0 || load_error !== 1'b1) begin
            fails++; $display("FAIL magic_restart: got reads=%0d busy=%b valid=%b err=%b want 1 0 0 1",
                              req_q.size(), busy, mem_req_valid, load_error); end
        tests++; if (q1.size() + q2.size() + q3.size() != 0) begin
            fails++; $display("FAIL magic_writes: got %0d want 0", q1.size() + q2.size() + q3.size()); end
    endtask

    task automatic test_header_limits();
        logic [31:0] hdrs [4];
        logic        exp_err [4];
        int cyc;
        bit to;
        hdrs[0] = 32'hD1C0_0009; exp_err[0] = 1'b1;
        hdrs[1] = 32'hD1C0_0210; exp_err[1] = 1'b1;
        hdrs[2] = 32'hD1C4_0400; exp_err[2] = 1'b1;
        hdrs[3] = 32'hD1C8_0000; exp_err[3] = 1'b0;
        lat_rand = 1'b0; lat_fixed = 1;
        for (int k = 0; k < 4; k++) begin
            img[0] = hdrs[k];
            do_reset(); clear_logs();
            pulse_start();
            wait_done(20, cyc, to);
            tests++;
            if (to || load_error !== exp_err[k] || dict_ready !== !exp_err[k]
                || q1.size() + q2.size() + q3.size() != 0) begin
                fails++; $display("FAIL hdr_limit_%0d: got err=%b ready=%b writes=%0d want err=%b ready=%b writes=0",
                                  k, load_error, dict_ready, q1.size() + q2.size() + q3.size(), exp_err[k], !exp_err[k]);
            end
        end
    endtask

    task automatic test_n3_full();
        int cyc;
        bit to;
        int bad;
        logic [14:0] exp_v;
        img[0] = 32'hD1C4_0000;
        for (int i = 1; i <= 256; i++) img[i] = 32'hFFFF_8000 | {17'd0, 15'(i * 129)};
        lat_rand = 1'b0; lat_fixed = 0;
        do_reset(); clear_logs();
        pulse_start();
        wait_done(2000, cyc, to);
        tests++; if (to || dict_ready !== 1'b1) begin
            fails++; $display("FAIL n3_done: got ready=%b timeout=%b want 1 0", dict_ready, to); end
        bad = 0;
        for (int i = 1; i <= 256; i++) begin
            exp_v = 15'(i * 129);
            if (q3[i-1] !== exp_v) bad++;
        end
        tests++; if (q3.size() != 256 || bad != 0 || q1.size() + q2.size() != 0) begin
            fails++; $display("FAIL n3_writes: got n3=%0d wrong=%0d other=%0d want 256 0 0",
                              q3.size(), bad, q1.size() + q2.size()); end
        tests++; if (req_q.size() != 257 || req_q[req_q.size()-1] !== 32'h0000_F400) begin
            fails++; $display("FAIL n3_last_addr: got n=%0d last=%h want 257 f400", req_q.size(), req_q[req_q.size()-1]); end
    endtask

    task automatic test_reset_mid_load();
        int cyc;
        bit to;
        bit found;
        img[0] = 32'hD1C0_0041;
        img[1] = 32'h0000_0011;
        img[2] = 32'h0000_0101;
        img[3] = 32'h0000_0102;
        img[4] = 32'h0000_0103;
        img[5] = 32'h0000_0104;
        lat_rand = 1'b0; lat_fixed = 3;
        do_reset(); clear_logs();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_req_valid && mem_req_addr == 32'h0000_F010) begin found = 1'b1; break; end
        end
        tests++; if (!found) begin fails++; $display("FAIL midrst_reach: third dict2 request never seen"); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({busy, dict_ready, load_error, mem_req_valid, dict1_write_enable, dict2_write_enable, dict3_write_enable} !== 7'b0
            || mem_req_addr !== 32'h0) begin
            fails++; $display("FAIL midrst_outputs: got flags=%b addr=%h want 0 0",
                              {busy, dict_ready, load_error, mem_req_valid, dict1_write_enable, dict2_write_enable,
                               dict3_write_enable}, mem_req_addr);
        end
        repeat (4) @(negedge clk);
        tests++; if (q1.size() != 1 || q2.size() != 2 || q3.size() != 0) begin
            fails++; $display("FAIL midrst_partial: got %0d/%0d/%0d want 1/2/0", q1.size(), q2.size(), q3.size()); end
        @(posedge clk);
        #1 reset = 1'b0;
        clear_logs();
        pulse_start();
        wait_done(300, cyc, to);
        tests++; if (to || dict_ready !== 1'b1 || req_q.size() != 6 || req_q[0] !== 32'h0000_F000) begin
            fails++; $display("FAIL midrst_reload: got ready=%b reads=%0d first=%h want 1 6 f000",
                              dict_ready, req_q.size(), req_q[0]); end
        tests++;
        if (q1.size() != 1 || q1[0] !== 7'h11 || q2.size() != 4 || q2[0] !== 10'h101 || q2[1] !== 10'h102
            || q2[2] !== 10'h103 || q2[3] !== 10'h104) begin
            fails++; $display("FAIL midrst_values: got d1n=%0d d2n=%0d d2=%h %h %h %h want 1 4 101 102 103 104",
                              q1.size(), q2.size(), q2[0], q2[1], q2[2], q2[3]);
        end
    endtask

    task automatic test_start_held();
        int cyc;
        bit to;
        int hdr_reads;
        load_mixed_image();
        lat_rand = 1'b1;
        do_reset(); clear_logs();
        @(posedge clk);
        #1 start = 1'b1;
        wait_done(300, cyc, to);
        repeat (30) @(negedge clk);
        hdr_reads = 0;
        foreach (req_q[i]) if (req_q[i] == 32'h0000_F000) hdr_reads++;
        tests++; if (to || dict_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL held_done: got ready=%b busy=%b timeout=%b want 1 0 0", dict_ready, busy, to); end
        tests++; if (hdr_reads != 1 || req_q.size() != 5) begin
            fails++; $display("FAIL held_single_load: got hdr_reads=%0d reads=%0d want 1 5", hdr_reads, req_q.size()); end
        tests++;
        if (q1.size() != 2 || q1[0] !== 7'h13 || q1[1] !== 7'h33 || q2.size() != 1 || q2[0] !== 10'h2A5
            || q3.size() != 1 || q3[0] !== 15'h7FFF) begin
            fails++; $display("FAIL held_values: got n=%0d/%0d/%0d want 2/1/1 with 13 33 2a5 7fff",
                              q1.size(), q2.size(), q3.size());
        end
        tests++; if (stab_err != 0) begin fails++; $display("FAIL held_stability: got %0d violations want 0", stab_err); end
        tests++; if (multi_we != 0 || val_err != 0) begin
            fails++; $display("FAIL held_enables: got multi=%0d val=%0d want 0 0", multi_we, val_err); end
        #1 start = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        lat_rand  = 1'b0;
        lat_fixed = 0;
        cur_lat   = 0;
        for (int i = 0; i < 512; i++) img[i] = '0;
        test_reset();
        test_empty();
        test_mixed();
        test_bad_magic();
        test_header_limits();
        test_n3_full();
        test_reset_mid_load();
        test_start_held();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
